// File: rtl/tpu_mem_pkg.sv
// Shared definitions for the memory-bank front-end blocks.
//   rd_state_e      : burst reader control states
//   RD_FIFO_DEPTH   : output buffer depth (covers the one-cycle bank read latency)
package tpu_mem_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2
  } rd_state_e;

  localparam int RD_FIFO_DEPTH = 2;
  localparam int RD_FIFO_PTR_W = $clog2(RD_FIFO_DEPTH);
  localparam int RD_FIFO_CNT_W = $clog2(RD_FIFO_DEPTH + 1);

endpackage

// File: rtl/bank_burst_reader_if.sv
// Bus bundle for bank_burst_reader: burst command, write request, bank port
// and output stream.
//   slave  : the burst reader itself
//   master : the surrounding environment (requesters, bank, consumer)
interface bank_burst_reader_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10
);
  localparam int LEN_W = ADDR_W + 1;

  logic              cmd_valid;
  logic              cmd_ready;
  logic [ADDR_W-1:0] cmd_base;
  logic [LEN_W-1:0]  cmd_len;

  logic              wr_valid;
  logic              wr_ready;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;

  logic              bank_we;
  logic [ADDR_W-1:0] bank_addr;
  logic [DATA_W-1:0] bank_din;
  logic [DATA_W-1:0] bank_dout;

  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_last;

  logic              busy;

  modport slave (
    input  cmd_valid, cmd_base, cmd_len, wr_valid, wr_addr, wr_data,
           bank_dout, out_ready,
    output cmd_ready, wr_ready, bank_we, bank_addr, bank_din,
           out_valid, out_data, out_last, busy
  );

  modport master (
    output cmd_valid, cmd_base, cmd_len, wr_valid, wr_addr, wr_data,
           bank_dout, out_ready,
    input  cmd_ready, wr_ready, bank_we, bank_addr, bank_din,
           out_valid, out_data, out_last, busy
  );
endinterface

// File: rtl/bank_rd_fifo.sv
// Small output buffer for the burst reader. Push and pop may occur in the
// same cycle; the caller guarantees no push when full and no pop when empty.
//   clk, rst_n : clock, async active-low reset
//   push, din  : write entry
//   pop        : retire head entry
//   dout       : head entry (registered storage)
//   count      : occupancy
module bank_rd_fifo
  import tpu_mem_pkg::*;
#(
  parameter int W = 33
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [W-1:0]             din,
  input  logic                     pop,
  output logic [W-1:0]             dout,
  output logic [RD_FIFO_CNT_W-1:0] count
);

  logic [RD_FIFO_DEPTH-1:0][W-1:0] mem_q, mem_d;
  logic [RD_FIFO_PTR_W-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [RD_FIFO_CNT_W-1:0]        count_q, count_d;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign dout  = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/bank_burst_reader.sv
// Burst read engine + write mux in front of a single-port bank with a
// one-cycle registered read. Bursts read base..base+len-1 (address wraps)
// and stream the words out with a last-of-burst flag; single-word writes
// are forwarded to the bank only while idle.
//   clk, rst_n : clock, async active-low reset
//   bus.cmd_*  : burst command (base, len) handshake
//   bus.wr_*   : single-word write request handshake
//   bus.bank_* : bank port drive / read data
//   bus.out_*  : output word stream (valid/ready, last)
//   bus.busy   : controller not idle
module bank_burst_reader
  import tpu_mem_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10,
  parameter int LEN_W  = ADDR_W + 1
) (
  input logic               clk,
  input logic               rst_n,
  bank_burst_reader_if.slave bus
);

  rd_state_e         state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  issued_q, issued_d;
  logic              inflight_q, inflight_d;
  logic              infl_last_q, infl_last_d;

  logic                     idle, wr_fire, cmd_fire, pop, issue, issue_last;
  logic [RD_FIFO_CNT_W-1:0] fifo_count;
  logic [RD_FIFO_CNT_W:0]   credit;
  logic [DATA_W:0]          fifo_head;

  assign idle          = (state_q == IDLE);
  // Ready outputs are forced low while reset is asserted.
  assign bus.wr_ready  = rst_n && idle;
  assign bus.cmd_ready = rst_n && idle && !bus.wr_valid;
  assign wr_fire       = bus.wr_valid && bus.wr_ready;
  assign cmd_fire      = bus.cmd_valid && bus.cmd_ready;
  assign bus.busy      = !idle;

  assign bus.out_valid = (fifo_count != '0);
  assign bus.out_data  = bus.out_valid ? fifo_head[DATA_W-1:0] : '0;
  assign bus.out_last  = bus.out_valid && fifo_head[DATA_W];
  assign pop           = bus.out_valid && bus.out_ready;

  // Words buffered plus the one still coming out of the bank may never
  // exceed the buffer depth; a same-cycle pop frees one slot.
  assign credit     = {1'b0, fifo_count} + {{RD_FIFO_CNT_W{1'b0}}, inflight_q};
  assign issue      = (state_q == READ) &&
                      ((credit < (RD_FIFO_CNT_W+1)'(RD_FIFO_DEPTH)) ||
                       ((credit == (RD_FIFO_CNT_W+1)'(RD_FIFO_DEPTH)) && pop));
  assign issue_last = (issued_q == len_q - LEN_W'(1));

  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    len_d       = len_q;
    issued_d    = issued_q;
    inflight_d  = issue;
    infl_last_d = issue && issue_last;
    case (state_q)
      IDLE: begin
        // Zero-length commands handshake and are dropped.
        if (cmd_fire && (bus.cmd_len != '0)) begin
          base_d   = bus.cmd_base;
          len_d    = bus.cmd_len;
          issued_d = '0;
          state_d  = READ;
        end
      end
      READ: begin
        if (issue) begin
          issued_d = issued_q + 1'b1;
          if (issue_last) state_d = DRAIN;
        end
      end
      DRAIN: begin
        // Leave as soon as the buffer will be empty after this cycle, so
        // busy drops the cycle after the last word is taken.
        if (!inflight_q &&
            ((fifo_count == '0) || ((fifo_count == RD_FIFO_CNT_W'(1)) && pop)))
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.bank_we   = 1'b0;
    bus.bank_addr = '0;
    bus.bank_din  = '0;
    if (wr_fire) begin
      bus.bank_we   = 1'b1;
      bus.bank_addr = bus.wr_addr;
      bus.bank_din  = bus.wr_data;
    end else if (issue) begin
      bus.bank_addr = base_q + issued_q[ADDR_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      base_q      <= '0;
      len_q       <= '0;
      issued_q    <= '0;
      inflight_q  <= 1'b0;
      infl_last_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      len_q       <= len_d;
      issued_q    <= issued_d;
      inflight_q  <= inflight_d;
      infl_last_q <= infl_last_d;
    end
  end

  // The last-of-burst tag rides alongside the bank word.
  bank_rd_fifo #(.W(DATA_W + 1)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (inflight_q),
    .din   ({infl_last_q, bus.bank_dout}),
    .pop   (pop),
    .dout  (fifo_head),
    .count (fifo_count)
  );

endmodule

// File: tb/tb_bank_burst_reader.sv
module tb_bank_burst_reader;
  localparam int DW = 32;
  localparam int AW = 10;
  localparam int LW = AW + 1;
  localparam int DEPTH = 1 << AW;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bank_burst_reader_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();
  bank_burst_reader #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Bank model: registered read, write at the edge.
  logic [DW-1:0] mem [DEPTH];
  logic          preload = 1'b0;
  always @(posedge clk) begin
    if (preload) begin
      for (int a = 0; a < DEPTH; a++) mem[a] <= DW'(a);
    end else if (bus.bank_we) begin
      mem[bus.bank_addr] <= bus.bank_din;
    end
    bus.bank_dout <= mem[bus.bank_addr];
  end

  // Reference contents of the bank as the bench believes them to be.
  logic [DW-1:0] ref_mem [DEPTH];

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Scoreboard: {last, data} per expected word.
  logic [DW:0] expq[$];
  int          n_pop = 0;
  logic        stall = 1'b0;
  logic [DW:0] held;

  always @(negedge clk) begin
    if (rst_n) begin
      if (stall) begin
        chk("valid_held", 64'(bus.out_valid), 64'd1);
        chk("stable", 64'({bus.out_last, bus.out_data}), 64'(held));
      end
      if (bus.out_valid) begin
        if (bus.out_ready) begin
          if (expq.size() == 0) chk("unexpected_out", 64'(bus.out_valid), 64'd0);
          else begin
            chk("out_word", 64'({bus.out_last, bus.out_data}), 64'(expq.pop_front()));
            n_pop++;
          end
          stall = 1'b0;
        end else begin
          stall = 1'b1;
          held  = {bus.out_last, bus.out_data};
        end
      end else begin
        stall = 1'b0;
      end
    end
  end

  // out_ready driver: 0 always-on, 1 pattern 1-0-0-1, 2 random, 3 held low.
  int rdy_mode = 0;
  int rdy_ph = 0;
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       bus.out_ready = 1'b1;
      1:       bus.out_ready = (rdy_ph % 4 == 0) || (rdy_ph % 4 == 3);
      2:       bus.out_ready = 1'($urandom_range(0, 1));
      default: bus.out_ready = 1'b0;
    endcase
    rdy_ph++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_burst(input int base, input int len);
    for (int i = 0; i < len; i++)
      expq.push_back({1'(i == len - 1), ref_mem[(base + i) % DEPTH]});
  endtask

  // Returns at the start of the cycle following the handshake.
  task automatic send_cmd(input int base, input int len, output int waited);
    logic hs;
    hs = 1'b0;
    waited = 0;
    bus.cmd_valid = 1'b1;
    bus.cmd_base  = AW'(base);
    bus.cmd_len   = LW'(len);
    for (int k = 0; k < 500; k++) begin
      @(negedge clk);
      hs = bus.cmd_ready;
      tick();
      if (hs) break;
      waited++;
    end
    chk("cmd_accept", 64'(hs), 64'd1);
    bus.cmd_valid = 1'b0;
  endtask

  task automatic do_write(input int addr, input logic [DW-1:0] data);
    bus.wr_valid = 1'b1;
    bus.wr_addr  = AW'(addr);
    bus.wr_data  = data;
    @(negedge clk);
    chk("wr_ready_idle", 64'(bus.wr_ready), 64'd1);
    tick();
    bus.wr_valid = 1'b0;
    ref_mem[addr % DEPTH] = data;
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      if (expq.size() == 0 && !bus.busy) break;
    end
    chk("drain_done", 64'({expq.size() == 0, bus.busy}), 64'b10);
    tick();
  endtask

  initial begin
    int w, base, len, nw;
    logic [DW-1:0] d;
    bus.cmd_valid = 1'b0; bus.cmd_base = '0; bus.cmd_len = '0;
    bus.wr_valid  = 1'b1; bus.wr_addr = AW'(10'h55); bus.wr_data = 32'hDEAD_BEEF;
    for (int a = 0; a < DEPTH; a++) ref_mem[a] = DW'(a);
    preload = 1'b1;
    tick(); tick();
    preload = 1'b0;
    @(negedge clk);
    // Reset state, with a write request pending that must not be taken.
    chk("rst_cmd_ready", 64'(bus.cmd_ready), 64'd0);
    chk("rst_wr_ready",  64'(bus.wr_ready), 64'd0);
    chk("rst_bank_we",   64'(bus.bank_we), 64'd0);
    chk("rst_bank_addr", 64'(bus.bank_addr), 64'd0);
    chk("rst_bank_din",  64'(bus.bank_din), 64'd0);
    chk("rst_out",       64'({bus.out_valid, bus.out_last, bus.out_data}), 64'd0);
    chk("rst_busy",      64'(bus.busy), 64'd0);
    bus.wr_valid = 1'b0;
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_cmd_ready", 64'(bus.cmd_ready), 64'd1);
    tick();

    // Directed burst: latency, throughput, last flag, busy timing.
    expect_burst(16, 4);
    send_cmd(16, 4, w);
    for (int j = 1; j <= 7; j++) begin
      @(negedge clk);
      if (j == 1) chk("first_addr", 64'({bus.bank_we, bus.bank_addr}), 64'h010);
      chk($sformatf("t1_valid_c%0d", j), 64'(bus.out_valid), 64'(j >= 3 && j <= 6));
      chk($sformatf("t1_last_c%0d", j),  64'(bus.out_last),  64'(j == 6));
      chk($sformatf("t1_busy_c%0d", j),  64'(bus.busy),      64'(j <= 6));
    end
    wait_idle();

    // Address wrap.
    expect_burst(10'h3FE, 4);
    send_cmd(10'h3FE, 4, w);
    wait_idle();

    // Backpressure pattern 1-0-0-1.
    rdy_mode = 1;
    expect_burst(10'h040, 8);
    send_cmd(10'h040, 8, w);
    wait_idle();

    // Consumer stalled: issue must stop at two outstanding; writes blocked.
    rdy_mode = 3;
    tick();
    expect_burst(10'h140, 8);
    send_cmd(10'h140, 8, w);
    bus.wr_valid = 1'b1; bus.wr_addr = AW'(10'h141); bus.wr_data = 32'h1234_5678;
    for (int j = 0; j < 6; j++) tick();
    @(negedge clk);
    chk("stall_no_issue", 64'(bus.bank_addr), 64'd0);
    chk("read_wr_ready",  64'(bus.wr_ready), 64'd0);
    chk("read_bank_we",   64'(bus.bank_we), 64'd0);
    chk("stall_busy",     64'(bus.busy), 64'd1);
    tick();
    bus.wr_valid = 1'b0;
    rdy_mode = 0;
    wait_idle();

    // Write/command contention: write wins, command next cycle.
    d = $urandom;
    bus.wr_valid = 1'b1; bus.wr_addr = AW'(10'h200); bus.wr_data = d;
    bus.cmd_valid = 1'b1; bus.cmd_base = AW'(10'h1FF); bus.cmd_len = LW'(3);
    @(negedge clk);
    chk("cont_cmd_ready", 64'(bus.cmd_ready), 64'd0);
    chk("cont_wr_ready",  64'(bus.wr_ready), 64'd1);
    chk("cont_bank", 64'({bus.bank_we, bus.bank_addr}), 64'({1'b1, 10'h200}));
    chk("cont_din",  64'(bus.bank_din), 64'(d));
    tick();
    bus.wr_valid = 1'b0;
    ref_mem[10'h200] = d;
    expect_burst(10'h1FF, 3);
    send_cmd(10'h1FF, 3, w);
    chk("cont_cmd_next", 64'(w), 64'd0);
    wait_idle();

    // Zero-length command.
    send_cmd(10'h123, 0, w);
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      chk("len0_busy_valid", 64'({bus.busy, bus.out_valid}), 64'd0);
    end
    tick();

    // Random bursts with random writes and random backpressure.
    rdy_mode = 2;
    for (int it = 0; it < 12; it++) begin
      nw = $urandom_range(0, 2);
      for (int k = 0; k < nw; k++) do_write($urandom_range(0, DEPTH - 1), $urandom);
      base = $urandom_range(0, DEPTH - 1);
      len  = $urandom_range(1, 24);
      expect_burst(base, len);
      send_cmd(base, len, w);
      wait_idle();
    end

    // Reset in the middle of a burst.
    rdy_mode = 0;
    tick();
    nw = n_pop;
    expect_burst(10'h080, 8);
    send_cmd(10'h080, 8, w);
    for (int k = 0; k < 100; k++) begin
      if (n_pop >= nw + 3) break;
      tick();
    end
    chk("mid_pops", 64'(n_pop - nw), 64'd3);
    rst_n = 1'b0;
    expq.delete();
    stall = 1'b0;
    #1;
    chk("midrst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("midrst_busy",      64'(bus.busy), 64'd0);
    chk("midrst_last",      64'(bus.out_last), 64'd0);
    tick(); tick();
    rst_n = 1'b1;
    tick();
    expect_burst(10'h090, 5);
    send_cmd(10'h090, 5, w);
    wait_idle();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/bank_burst_reader.md
# bank_burst_reader

Burst read engine and write-port mux sitting directly in front of a single-port synchronous memory bank (1R/1W, registered read data, one-cycle read latency). It accepts a burst command (base address, length), issues sequential reads to the bank, absorbs the fixed read latency in a 2-entry output buffer, and presents the words as a valid/ready stream to the downstream consumer (systolic-array feeder). In idle it forwards single-word write requests to the bank.

## Interface
- DATA_W, 32, memory word width
- ADDR_W, 10, bank address width; bank depth 2^ADDR_W
- LEN_W, ADDR_W+1, burst length width; max burst 2^ADDR_W words
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  reset, asynchronous assert, active-low
- cmd_valid / cmd_ready  in / out  1  burst command handshake
- cmd_base  in  ADDR_W  first read address
- cmd_len  in  LEN_W  number of words
- wr_valid / wr_ready  in / out  1  write request handshake
- wr_addr  in  ADDR_W; wr_data  in  DATA_W  write address/data
- bank_we  out  1; bank_addr  out  ADDR_W; bank_din  out  DATA_W  bank port drive
- bank_dout  in  DATA_W  bank read data, valid the cycle after bank_addr is sampled
- out_valid / out_ready  out / in  1  output stream handshake
- out_data  out  DATA_W; out_last  out  1  stream word, last-of-burst flag
- busy  out  1  high in any state other than IDLE

One clock; reset is asynchronous and active-low.

## Operation
- States: IDLE, READ, DRAIN.
- IDLE: wr_ready=1; cmd_ready = !wr_valid (writes take priority). On write handshake: bank_we=1, bank_addr=wr_addr, bank_din=wr_data combinationally, same cycle.
- Command with cmd_len=0: accepted, no reads, no output, stays IDLE.
- Command with cmd_len>0: latch base and len, reset issue counter, go READ. Writes blocked (wr_ready=0) in READ and DRAIN.
- READ: issue read (bank_we=0, bank_addr = base+issued, modulo 2^ADDR_W, wrap silently) when credit allows: fifo_count + inflight < 2, or = 2 with an output pop this cycle. Last issue -> DRAIN.
- inflight flag set the cycle after an issue; that cycle bank_dout is pushed into the output FIFO.
- DRAIN: no issues; when FIFO empty and no inflight -> IDLE (cmd_ready may assert that next cycle).
- out_last asserted with the word whose index = len-1; tag travels with the data through the FIFO.
- out_data/out_valid/out_last stable while out_valid && !out_ready.
- bank_addr/bank_din drive 0 when no access; bank_we=0 except on write handshake.

## Timing
- Reset values: cmd_ready=0 during reset, 1 after (if !wr_valid); wr_ready=0 in reset; bank_we=0, bank_addr=0, bank_din=0; out_valid=0, out_last=0, out_data=0; busy=0; state IDLE; FIFO empty, inflight=0.
- Latency: cmd handshake in cycle 0 -> first read issued cycle 1 -> bank_dout cycle 2 -> out_valid cycle 3.
- Throughput: out_ready held high -> one word per cycle, no bubbles; burst of N completes with out_last in cycle N+2, IDLE (busy=0) in cycle N+3.
- Backpressure: FIFO never overflows; with out_ready=0, at most 2 words outstanding (FIFO+inflight), issue stalls until pop.
- Write: single cycle, accepted only in IDLE; data in bank at following edge.
- Reset mid-burst: all state cleared immediately, partial burst discarded, no out_last emitted.

## Structure
- Shared package tpu_mem_pkg: state enum typedef (IDLE/READ/DRAIN), FIFO depth constant RD_FIFO_DEPTH=2.
- One sub-module: bank_rd_fifo (2-entry, DATA_W+1 bits wide, push/pop same cycle allowed, count output, async active-low reset).

## Test plan
- Burst base=0x010, len=4, out_ready=1 with bank preloaded mem[a]=a -> out_data 0x10..0x13 in cycles 3-6, out_last only on 0x13, busy low cycle 7.
- Wrap: base=0x3FE, len=4 (ADDR_W=10) -> addresses 0x3FE,0x3FF,0x000,0x001 in order.
- Backpressure: len=8, out_ready toggled 1-0-0-1 pattern -> all 8 words in order, no loss/duplication, never >2 outstanding.
- Write/cmd contention in IDLE: wr_valid and cmd_valid same cycle -> write accepted first (cmd_ready=0), command accepted next cycle, burst reads the new data.
- cmd_len=0 -> handshake completes, no out_valid, busy stays 0; writes during READ see wr_ready=0.
- Assert rst_n low mid-burst (after 3 of 8 words) -> out_valid=0 and busy=0 immediately; new burst after release behaves normally.
